// File: rtl/weight_sram_pkg.sv
// Shared types and width helpers for the banked weight-SRAM controller.
package weight_sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Address/select width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned w;
    w = $clog2(v);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/weight_sram_bank.sv
// One bank: active-high cs/we converted to active-low macro pins, behavioural macro body.
module weight_sram_bank #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BANK_AW = 11
) (
  input  logic               clock,
  input  logic               cs,
  input  logic               we,
  input  logic [BANK_AW-1:0] addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata
);

  logic csb0;
  logic web0;
  logic [DATA_W-1:0] mem [2**BANK_AW];

  assign csb0 = ~cs;
  assign web0 = ~we;

  always_ff @(posedge clock) begin
    if (!csb0) begin
      if (!web0) mem[addr] <= wdata;
      else       rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/weight_sram_banked_ctrl.sv
// Banked weight-SRAM controller: burst request FSM, flat address counter, read-return mux.
module weight_sram_banked_ctrl
  import weight_sram_pkg::*;
#(
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned BANK_DEPTH = 2048,
  parameter  int unsigned NUM_BANKS  = 25,
  parameter  int unsigned ADDR_W     = 32,
  parameter  int unsigned BURST_MAX  = 16,
  localparam int unsigned BANK_AW    = clog2_min1(BANK_DEPTH),
  localparam int unsigned BSEL_W     = clog2_min1(NUM_BANKS),
  localparam int unsigned LEN_W      = clog2_min1(BURST_MAX)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              wr_done,
  output logic              err
);

  localparam logic [BSEL_W:0] NB = (BSEL_W+1)'(NUM_BANKS);

  state_t             state;
  logic [BSEL_W-1:0]  cur_bank;
  logic [BSEL_W-1:0]  rd_bank;
  logic [BANK_AW-1:0] cur_word;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   beat_cnt;

  logic               issue;
  logic               bank_we;
  logic               last_beat;
  logic               wrap;
  logic               wrap_oob;
  logic [BSEL_W:0]    req_bank_ext;
  logic [BSEL_W:0]    next_bank_ext;
  logic [NUM_BANKS-1:0] bank_cs;
  logic [DATA_W-1:0]  bank_rdata [NUM_BANKS];

  if (ADDR_W > BANK_AW + BSEL_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_W-1:BANK_AW+BSEL_W];
  end

  assign req_bank_ext  = {1'b0, req_addr[BANK_AW +: BSEL_W]};
  assign issue         = (state == READ) || ((state == WRITE) && wr_valid && wr_ready);
  assign bank_we       = (state == WRITE);
  assign last_beat     = (beat_cnt == len);
  assign wrap          = (cur_word == '1);
  assign next_bank_ext = {1'b0, cur_bank} + 1'b1;
  assign wrap_oob      = wrap && (next_bank_ext >= NB);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      wr_done   <= 1'b0;
      err       <= 1'b0;
      cur_bank  <= '0;
      cur_word  <= '0;
      rd_bank   <= '0;
      len       <= '0;
      beat_cnt  <= '0;
    end else begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      wr_done  <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (req_valid) begin
            req_ready <= 1'b0;
            cur_bank  <= req_addr[BANK_AW +: BSEL_W];
            cur_word  <= req_addr[BANK_AW-1:0];
            len       <= req_len;
            beat_cnt  <= '0;
            if (req_bank_ext >= NB) begin
              err <= 1'b1;
            end else if (req_write) begin
              state    <= WRITE;
              wr_ready <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        READ, WRITE: begin
          if (issue) begin
            if (state == READ) begin
              rd_valid <= 1'b1;
              rd_bank  <= cur_bank;
            end
            beat_cnt <= beat_cnt + 1'b1;
            cur_word <= cur_word + 1'b1;
            if (wrap) cur_bank <= next_bank_ext[BSEL_W-1:0];
            // A wrap off the last bank only matters if more beats were still owed.
            if (last_beat) begin
              state     <= IDLE;
              req_ready <= 1'b1;
              wr_ready  <= 1'b0;
              if (state == READ) rd_last <= 1'b1;
              else               wr_done <= 1'b1;
            end else if (wrap_oob) begin
              state     <= IDLE;
              req_ready <= 1'b1;
              wr_ready  <= 1'b0;
              err       <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bank_cs = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_cs[b] = issue && (cur_bank == BSEL_W'(b));
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    weight_sram_bank #(
      .DATA_W (DATA_W),
      .BANK_AW(BANK_AW)
    ) u_bank (
      .clock(clock),
      .cs   (bank_cs[b]),
      .we   (bank_we),
      .addr (cur_word),
      .wdata(wr_data),
      .rdata(bank_rdata[b])
    );
  end

  // Return data follows the bank captured at issue, not the live address.
  always_comb begin
    rd_data = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (rd_valid && (rd_bank == BSEL_W'(b))) rd_data = bank_rdata[b];
    end
  end

endmodule

// File: tb/tb_weight_sram_banked_ctrl.sv
// Table-driven bench for weight_sram_banked_ctrl with a read-data scoreboard and flat-address model.
module tb_weight_sram_banked_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        wr_done;
  logic        err;

  weight_sram_banked_ctrl #(
    .DATA_W    (32),
    .BANK_DEPTH(2048),
    .NUM_BANKS (25),
    .ADDR_W    (32),
    .BURST_MAX (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_len  (req_len),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .wr_done  (wr_done),
    .err      (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    int          len;
    logic [31:0] d0;
    int          gap_at;
    int          gap_n;
    int          exp_beats;
    bit          exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } rd_exp_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int cs_cnt = 0, commit_cnt = 0, err_cnt = 0, wd_cnt = 0, multi_cs = 0;
  int last_wr_issue = -10;
  rd_exp_t rd_q[$];
  int iss_q[$];
  logic [31:0] model [logic [15:0]];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      if (!$onehot0(dut.bank_cs)) multi_cs++;
      if (|dut.bank_cs) begin
        cs_cnt += $countones(dut.bank_cs);
        if (wr_ready) begin
          commit_cnt++;
          last_wr_issue = cyc;
        end else begin
          iss_q.push_back(cyc);
        end
      end
      if (rd_valid) begin
        if (rd_q.size() == 0 || iss_q.size() == 0) begin
          check("rd_unexpected", 32'(rd_q.size()), 32'd1);
        end else begin
          rd_exp_t e;
          int      ic;
          e  = rd_q.pop_front();
          ic = iss_q.pop_front();
          check("rd_data", rd_data, e.data);
          check("rd_last", 32'(rd_last), 32'(e.last));
          check("rd_latency", 32'(cyc), 32'(ic + 1));
        end
      end
      if (err) err_cnt++;
      if (wr_done) begin
        wd_cnt++;
        check("wr_done_latency", 32'(cyc), 32'(last_wr_issue + 1));
      end
    end
  end

  task automatic wait_ready(input string name);
    int t;
    t = 0;
    while (!req_ready && t < 60) begin
      @(posedge clock); #1;
      t++;
    end
    check(name, 32'(req_ready), 32'd1);
  endtask

  task automatic run_req(input vec_t v);
    logic [15:0] a;
    int err0, wd0, cmt0, cs0;
    a = v.addr[15:0];
    for (int k = 0; k < v.exp_beats; k++) begin
      if (v.wr) model[a] = v.d0 + 32'(k);
      else rd_q.push_back('{data: model[a], last: (v.exp_beats == v.len + 1) && (k == v.len)});
      a = a + 16'd1;
    end
    err0 = err_cnt; wd0 = wd_cnt; cmt0 = commit_cnt; cs0 = cs_cnt;
    wait_ready("req_ready_before");
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_len = 4'(v.len);
    @(posedge clock); #1;
    req_valid = 1'b0;
    if (v.exp_beats == 0 && v.exp_err) begin
      check("err_at_accept", 32'(err), 32'd1);
      check("ready_drop", 32'(req_ready), 32'd0);
      @(posedge clock); #1;
      check("ready_back", 32'(req_ready), 32'd1);
      check("err_clear", 32'(err), 32'd0);
    end else if (v.wr) begin
      for (int k = 0; k < v.exp_beats; k++) begin
        if (k == v.gap_at) begin
          wr_valid = 1'b0;
          repeat (v.gap_n) begin @(posedge clock); #1; end
        end
        check("wr_ready_beat", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1; wr_data = v.d0 + 32'(k);
        @(posedge clock); #1;
      end
      wr_valid = 1'b0;
    end
    wait_ready("req_ready_after");
    repeat (2) @(posedge clock);
    #1;
    check("err_count", 32'(err_cnt - err0), 32'(v.exp_err));
    check("wr_done_count", 32'(wd_cnt - wd0), 32'(v.wr && !v.exp_err));
    check("commit_count", 32'(commit_cnt - cmt0), v.wr ? 32'(v.exp_beats) : 32'd0);
    check("cs_count", 32'(cs_cnt - cs0), 32'(v.exp_beats));
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("wr_ready_idle", 32'(wr_ready), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //                wr    addr                       len d0            gap    beats err
    vecs.push_back('{1'b1, 32'h0000_0805,               0, 32'hDEADBEEF, -1, 0,  1, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0805,               0, 32'h0,        -1, 0,  1, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_07FE,               3, 32'd1,        -1, 0,  4, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_07FE,               3, 32'h0,        -1, 0,  4, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_1100,               2, 32'hA0,        1, 2,  3, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_1100,               2, 32'h0,        -1, 0,  3, 1'b0});
    vecs.push_back('{1'b0, 32'(25 << 11),               0, 32'h0,        -1, 0,  0, 1'b1});
    vecs.push_back('{1'b1, 32'(31 << 11),               2, 32'h77,       -1, 0,  0, 1'b1});
    vecs.push_back('{1'b1, 32'((24 << 11) | 32'h7FE),   3, 32'h50,       -1, 0,  2, 1'b1});
    vecs.push_back('{1'b0, 32'((24 << 11) | 32'h7FE),   3, 32'h0,        -1, 0,  2, 1'b1});
    vecs.push_back('{1'b1, 32'((24 << 11) | 32'h7FF),   0, 32'hCAFE,     -1, 0,  1, 1'b0});
    vecs.push_back('{1'b0, 32'((24 << 11) | 32'h7FF),   0, 32'h0,        -1, 0,  1, 1'b0});
    vecs.push_back('{1'b1, 32'hFFFF_2003,               7, 32'h100,      -1, 0,  8, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_2003,               7, 32'h0,        -1, 0,  8, 1'b0});
    vecs.push_back('{1'b0, 32'hABCD_2005,               0, 32'h0,        -1, 0,  1, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_3000,              15, 32'h200,      -1, 0, 16, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_3000,              15, 32'h0,        -1, 0, 16, 1'b0});

    repeat (2) @(posedge clock);
    #1;
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_last",  32'(rd_last),  32'd0);
    check("rst_wr_done",  32'(wr_done),  32'd0);
    check("rst_err",      32'(err),      32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_bank_cs",  32'(dut.bank_cs), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clock); #1;

    for (int i = 0; i < vecs.size(); i++) run_req(vecs[i]);

    // Burst that crossed the bank-0/bank-1 boundary lands in the right macros.
    check("mem_b0_7FE", dut.g_bank[0].u_bank.mem[2046], 32'd1);
    check("mem_b0_7FF", dut.g_bank[0].u_bank.mem[2047], 32'd2);
    check("mem_b1_000", dut.g_bank[1].u_bank.mem[0], 32'd3);
    check("mem_b1_001", dut.g_bank[1].u_bank.mem[1], 32'd4);

    // Reset in the middle of an 8-beat read.
    wait_ready("ready_before_rst");
    rd_q.push_back('{data: model[16'h2003], last: 1'b0});
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_2003; req_len = 4'd7;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_rd_last",  32'(rd_last),  32'd0);
    check("mid_rst_rd_data",  rd_data,        32'd0);
    check("mid_rst_err",      32'(err),       32'd0);
    check("mid_rst_wr_done",  32'(wr_done),   32'd0);
    check("mid_rst_bank_cs",  32'(dut.bank_cs), 32'd0);
    check("pre_rst_beat_popped", 32'(rd_q.size()), 32'd0);
    rd_q.delete();
    iss_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    v = '{1'b0, 32'h0000_2003, 0, 32'h0, -1, 0, 1, 1'b0};
    run_req(v);
    v = '{1'b0, 32'h0000_2008, 1, 32'h0, -1, 0, 2, 1'b0};
    run_req(v);

    check("multi_bank_select", 32'(multi_cs), 32'd0);
    check("issue_q_drained", 32'(iss_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
